// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: two writeback requesters plus the registered regfile write port.
interface regfile_write_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int ADDRBITS = 5,
  parameter int CNTBITS  = 8
);
  logic                req0_valid;
  logic [ADDRBITS-1:0] req0_addr;
  logic [WIDTH-1:0]    req0_data;
  logic                req0_ready;
  logic                req1_valid;
  logic [ADDRBITS-1:0] req1_addr;
  logic [WIDTH-1:0]    req1_data;
  logic                req1_ready;
  logic                wrenable;
  logic [ADDRBITS-1:0] wr_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                grant_id;
  logic [CNTBITS-1:0]  collision_count;
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, wrenable, wr_addr, wr_data, grant_id, collision_count
  );
  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, wrenable, wr_addr, wr_data, grant_id, collision_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the regfile write port between two writeback requesters.
module regfile_write_arbiter #(
  parameter int WIDTH    = 32,
  parameter int ADDRBITS = 5,
  parameter int CNTBITS  = 8
) (
  input logic clk,
  input logic reset,
  regfile_write_arbiter_if.slave bus
);
  logic                last_grant_q, wrenable_q, grant_id_q;
  logic [ADDRBITS-1:0] wr_addr_q, gnt_addr;
  logic [WIDTH-1:0]    wr_data_q, gnt_data;
  logic [CNTBITS-1:0]  count_q, count_d;
  logic                both, any, gnt;
  always_comb begin
    both     = bus.req0_valid & bus.req1_valid;
    any      = (bus.req0_valid | bus.req1_valid) & ~reset;
    gnt      = both ? ~last_grant_q : bus.req1_valid;
    gnt_addr = gnt ? bus.req1_addr : bus.req0_addr;
    gnt_data = gnt ? bus.req1_data : bus.req0_data;
    count_d  = (both && count_q != '1) ? count_q + CNTBITS'(1) : count_q;
  end
  assign bus.req0_ready      = any & ~gnt;
  assign bus.req1_ready      = any & gnt;
  assign bus.wrenable        = wrenable_q;
  assign bus.wr_addr         = wr_addr_q;
  assign bus.wr_data         = wr_data_q;
  assign bus.grant_id        = grant_id_q;
  assign bus.collision_count = count_q;
  // last_grant resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      wrenable_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      grant_id_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      wrenable_q <= any && gnt_addr != '0;
      count_q    <= count_d;
      if (any) begin
        last_grant_q <= gnt;
        wr_addr_q    <= gnt_addr;
        wr_data_q    <= gnt_data;
        grant_id_q   <= gnt;
      end
    end
  end
endmodule
